// File: rtl/cpu_types_pkg.sv
// Shared CPU types: fetch FSM states, the IF/ID latch record and PC arithmetic.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t npc;
    logic  pred_taken;
    word_t pred_target;
  } ifid_t;

  localparam word_t PC_STEP = 32'd4;

  // Sequential PC; wraps naturally at 2^32.
  function automatic word_t pc_plus4(input word_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, BTB-steered next PC, IF/ID latch and the
// RUN/DRAIN/HALTED fetch FSM that parks a redirect until an outstanding miss returns.
module pc_fetch
  import cpu_types_pkg::*;
#(
  parameter word_t PC0 = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic [31:0] btb_pc,
  input  logic        btb_taken,
  input  logic [31:0] btb_target,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_npc,
  output logic        ifid_pred_taken,
  output logic [31:0] ifid_pred_target
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        redirect_pc_q, redirect_pc_d;
  ifid_t        ifid_q, ifid_d;
  logic         iren_q, iren_d;

  // Next-state, next-PC and IF/ID latch selection.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    ifid_d        = ifid_q;

    if (halt) begin
      state_d      = HALTED;
      ifid_d.valid = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_redirect) begin
            ifid_d.valid = 1'b0;
            if (ihit) begin
              pc_d = ex_target;
            end else begin
              // The miss in flight still targets the old PC; keep iaddr stable until it lands.
              redirect_pc_d = ex_target;
              state_d       = DRAIN;
            end
          end else if (stall) begin
            ifid_d = ifid_q;
          end else if (ihit) begin
            ifid_d.valid       = 1'b1;
            ifid_d.instr       = iload;
            ifid_d.pc          = pc_q;
            ifid_d.npc         = pc_plus4(pc_q);
            ifid_d.pred_taken  = btb_taken;
            ifid_d.pred_target = btb_target;
            pc_d               = btb_taken ? btb_target : pc_plus4(pc_q);
          end else begin
            ifid_d.valid = 1'b0;
          end
        end
        DRAIN: begin
          ifid_d.valid = 1'b0;
          if (ihit) begin
            pc_d    = ex_redirect ? ex_target : redirect_pc_q;
            state_d = RUN;
          end else if (ex_redirect) begin
            redirect_pc_d = ex_target;
          end else begin
            redirect_pc_d = redirect_pc_q;
          end
        end
        HALTED: begin
          ifid_d.valid = 1'b0;
        end
        default: begin
          state_d      = HALTED;
          ifid_d.valid = 1'b0;
        end
      endcase
    end

    iren_d = (state_d != HALTED);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q       <= RUN;
      pc_q          <= PC0;
      redirect_pc_q <= 32'h0000_0000;
      ifid_q        <= '0;
      iren_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      ifid_q        <= ifid_d;
      iren_q        <= iren_d;
    end
  end

  assign btb_pc           = pc_q;
  assign iaddr            = pc_q;
  assign iREN             = iren_q;
  assign ifid_valid       = ifid_q.valid;
  assign ifid_instr       = ifid_q.instr;
  assign ifid_pc          = ifid_q.pc;
  assign ifid_npc         = ifid_q.npc;
  assign ifid_pred_taken  = ifid_q.pred_taken;
  assign ifid_pred_target = ifid_q.pred_target;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a behavioural fetch model.
module tb_pc_fetch;
  import cpu_types_pkg::*;

  localparam word_t TB_PC0 = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0, stall = 1'b0, ex_redirect = 1'b0, btb_taken = 1'b0, ihit = 1'b0;
  word_t       ex_target = '0, btb_target = '0, iload = '0;
  word_t       btb_pc, iaddr, ifid_instr, ifid_pc, ifid_npc, ifid_pred_target;
  logic        iREN, ifid_valid, ifid_pred_taken;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  pc_fetch #(.PC0(TB_PC0)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .stall(stall),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .btb_pc(btb_pc), .btb_taken(btb_taken), .btb_target(btb_target),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_npc(ifid_npc), .ifid_pred_taken(ifid_pred_taken),
    .ifid_pred_target(ifid_pred_target)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: what the fetch stage must present after each edge.
  word_t m_pc, m_redir, m_instr, m_ipc, m_npc, m_ptgt;
  bit    m_halted, m_drain, m_v, m_ptaken;

  always @(posedge CLK) begin
    if (!nRST) begin
      m_pc = TB_PC0; m_redir = '0; m_halted = 0; m_drain = 0;
      m_v = 0; m_instr = '0; m_ipc = '0; m_npc = '0; m_ptaken = 0; m_ptgt = '0;
    end else if (m_halted || halt) begin
      m_halted = 1; m_v = 0;
    end else if (m_drain) begin
      m_v = 0;
      if (ex_redirect) m_redir = ex_target;
      if (ihit) begin m_pc = m_redir; m_drain = 0; end
    end else if (ex_redirect) begin
      m_v = 0;
      if (ihit) m_pc = ex_target;
      else begin m_redir = ex_target; m_drain = 1; end
    end else if (!stall) begin
      if (ihit) begin
        m_v = 1; m_instr = iload; m_ipc = m_pc; m_npc = m_pc + 32'd4;
        m_ptaken = btb_taken; m_ptgt = btb_target;
        m_pc = btb_taken ? btb_target : m_pc + 32'd4;
      end else begin
        m_v = 0;
      end
    end
  end

  task automatic chk(input string name, input word_t act, input word_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("iaddr", iaddr, m_pc);
      chk("btb_pc", btb_pc, m_pc);
      chk("iREN", {31'd0, iREN}, {31'd0, ~m_halted});
      chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_v});
      if (m_v) begin
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc", ifid_pc, m_ipc);
        chk("ifid_npc", ifid_npc, m_npc);
        chk("ifid_pred_taken", {31'd0, ifid_pred_taken}, {31'd0, m_ptaken});
        chk("ifid_pred_target", ifid_pred_target, m_ptgt);
      end
    end
  end

  task automatic step(input logic h, input logic st, input logic er, input word_t et,
                      input logic bt, input word_t btt, input logic ih, input word_t il);
    halt = h; stall = st; ex_redirect = er; ex_target = et;
    btb_taken = bt; btb_target = btt; ihit = ih; iload = il;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic fetch(input word_t il);
    step(0, 0, 0, '0, 0, '0, 1, il);
  endtask

  task automatic jump(input word_t tgt);
    step(0, 0, 1, tgt, 0, '0, 1, '0);
  endtask

  initial begin
    nRST = 1'b0;
    step(0, 0, 0, '0, 0, '0, 0, '0);
    step(0, 0, 0, '0, 0, '0, 0, '0);
    cmp_en = 1'b1;
    nRST = 1'b1;

    // Reset state
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_iren", {31'd0, iREN}, 32'd1);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc", ifid_pc, 32'h0);
    chk("rst_npc", ifid_npc, 32'h0);
    chk("rst_ptaken", {31'd0, ifid_pred_taken}, 32'd0);
    chk("rst_ptgt", ifid_pred_target, 32'h0);

    // Sequential fetch 0, 4, 8
    fetch(32'hA000_0000);
    chk("seq_iaddr4", iaddr, 32'h4);
    chk("seq_pc0", ifid_pc, 32'h0);
    chk("seq_valid", {31'd0, ifid_valid}, 32'd1);
    fetch(32'hA000_0004);
    chk("seq_iaddr8", iaddr, 32'h8);
    chk("seq_pc4", ifid_pc, 32'h4);
    chk("seq_npc8", ifid_npc, 32'h8);

    // BTB taken at 0x40
    jump(32'h40);
    chk("jmp_iaddr40", iaddr, 32'h40);
    chk("jmp_valid0", {31'd0, ifid_valid}, 32'd0);
    step(0, 0, 0, '0, 1, 32'h100, 1, 32'hB000_0040);
    chk("btb_iaddr", iaddr, 32'h100);
    chk("btb_ptaken", {31'd0, ifid_pred_taken}, 32'd1);
    chk("btb_ptgt", ifid_pred_target, 32'h100);
    chk("btb_pc40", ifid_pc, 32'h40);

    // Stall 3 cycles at PC 0x8
    jump(32'h4);
    fetch(32'hC000_0004);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, '0, 0, '0, 1, 32'hDEAD_BEEF);
      chk("stall_iaddr", iaddr, 32'h8);
      chk("stall_pc", ifid_pc, 32'h4);
      chk("stall_instr", ifid_instr, 32'hC000_0004);
    end
    fetch(32'hC000_0008);
    chk("unstall_iaddr", iaddr, 32'hC);
    chk("unstall_pc", ifid_pc, 32'h8);

    // Miss at 0x20 with two redirects, hit on cycle 5
    jump(32'h20);
    step(0, 0, 0, '0, 0, '0, 0, '0);
    chk("miss_iaddr", iaddr, 32'h20);
    step(0, 0, 1, 32'h80, 0, '0, 0, '0);
    chk("drain1_iaddr", iaddr, 32'h20);
    step(0, 0, 0, '0, 0, '0, 0, '0);
    chk("drain2_iaddr", iaddr, 32'h20);
    step(0, 0, 1, 32'h90, 0, '0, 0, '0);
    chk("drain3_iaddr", iaddr, 32'h20);
    chk("drain_valid", {31'd0, ifid_valid}, 32'd0);
    step(0, 0, 0, '0, 0, '0, 1, 32'hBAD0_0020);
    chk("drain_exit_iaddr", iaddr, 32'h90);
    chk("drain_discard", {31'd0, ifid_valid}, 32'd0);
    fetch(32'hE000_0090);
    chk("post_drain_pc", ifid_pc, 32'h90);
    chk("post_drain_iaddr", iaddr, 32'h94);

    // PC wrap
    jump(32'hFFFF_FFFC);
    fetch(32'hF000_0000);
    chk("wrap_iaddr", iaddr, 32'h0);
    chk("wrap_npc", ifid_npc, 32'h0);

    // Redirect with stall and hit together
    step(0, 1, 1, 32'h200, 0, '0, 1, '0);
    chk("rs_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rs_iaddr", iaddr, 32'h200);

    // Halt, then ignored redirects, then reset
    step(1, 0, 0, '0, 0, '0, 1, '0);
    chk("halt_iren", {31'd0, iREN}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, i[0], 1, 32'h300, 0, '0, 1, 32'h1234_5678);
      chk("halted_iren", {31'd0, iREN}, 32'd0);
      chk("halted_valid", {31'd0, ifid_valid}, 32'd0);
      chk("halted_iaddr", iaddr, 32'h200);
    end
    nRST = 1'b0;
    step(0, 0, 1, 32'h300, 0, '0, 1, '0);
    nRST = 1'b1;
    chk("rehalt_iaddr", iaddr, TB_PC0);
    chk("rehalt_iren", {31'd0, iREN}, 32'd1);

    // Randomized traffic; the compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      word_t et, bt;
      et = {$urandom(), 2'b00} >> 0;
      et = {et[31:2], 2'b00};
      bt = $urandom();
      bt = {bt[31:2], 2'b00};
      if ($urandom_range(0, 15) == 0) et = 32'hFFFF_FFF8;
      nRST = ($urandom_range(0, 63) != 0);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), et, ($urandom_range(0, 3) == 0), bt,
           ($urandom_range(0, 2) != 0), $urandom());
    end
    nRST = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
